bram_portb_arbiter: RTL and testbench

Shares port B of the 16-bit dual-port instruction/data BRAM among three requesters. Port A stays dedicated to the CPU. Requester 0 is the video fetch unit, which has fixed highest priority. Requesters 1 and 2 are the controller-input writer and the score/timer MMIO unit, which round-robin between themselves. A starvation guard bounds how long video can lock out requesters 1 and 2. The block returns read data with a per-requester valid strobe that matches the BRAM's one-cycle read latency.

---
 rtl/bram_portb_arbiter.sv | 132 +++++++++++++
 tb/tb_bram_portb_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bram_portb_arbiter.sv
// Port-B arbiter for the shared instruction/data BRAM: video (0) has fixed priority,
// requesters 1/2 round-robin, and a wait counter forces a low-priority grant after MAX_WAIT losses.
module bram_portb_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  req2,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  we2,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [ADDR_WIDTH-1:0] addr2,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [DATA_WIDTH-1:0] wdata2,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  gnt2,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic                  rvalid2,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] data_b,
    output logic                  we_b,
    input  logic [DATA_WIDTH-1:0] q_b
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [2:0]            gnt_vec;
    logic [2:0]            we_vec;
    logic [2:0]            rvalid_vec;
    logic [ADDR_WIDTH-1:0] addr_arr  [3];
    logic [DATA_WIDTH-1:0] wdata_arr [3];

    logic [1:0] rr_next_q, rr_next_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       rd_pend_q, rd_pend_d;
    logic [1:0] rd_id_q, rd_id_d;
    logic       low_req, starve_force, win1;

    assign we_vec       = {we2, we1, we0};
    assign addr_arr[0]  = addr0;
    assign addr_arr[1]  = addr1;
    assign addr_arr[2]  = addr2;
    assign wdata_arr[0] = wdata0;
    assign wdata_arr[1] = wdata1;
    assign wdata_arr[2] = wdata2;

    // Grant selection; everything is held off while reset_n is low.
    always_comb begin
        low_req      = req1 | req2;
        starve_force = (wait_cnt_q == MAX_WAIT_C);
        win1         = req1 & ((rr_next_q == 2'd1) | ~req2);
        gnt_vec      = 3'b000;
        if (reset_n) begin
            if (low_req && (starve_force || !req0)) begin
                gnt_vec = win1 ? 3'b010 : 3'b100;
            end else if (req0) begin
                gnt_vec = 3'b001;
            end
        end
    end

    always_comb begin
        addr_b    = '0;
        data_b    = '0;
        we_b      = 1'b0;
        rd_pend_d = 1'b0;
        rd_id_d   = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (gnt_vec[i]) begin
                addr_b    = addr_arr[i];
                data_b    = wdata_arr[i];
                we_b      = we_vec[i];
                rd_pend_d = ~we_vec[i];
                rd_id_d   = 2'(i);
            end
        end
    end

    always_comb begin
        rr_next_d  = rr_next_q;
        wait_cnt_d = wait_cnt_q;
        if (gnt_vec[1]) begin
            rr_next_d = 2'd2;
        end else if (gnt_vec[2]) begin
            rr_next_d = 2'd1;
        end
        if (gnt_vec[1] || gnt_vec[2] || !low_req) begin
            wait_cnt_d = 8'd0;
        end else if (gnt_vec[0] && (wait_cnt_q != MAX_WAIT_C)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_next_q  <= 2'd1;
            wait_cnt_q <= 8'd0;
            rd_pend_q  <= 1'b0;
            rd_id_q    <= 2'd0;
        end else begin
            rr_next_q  <= rr_next_d;
            wait_cnt_q <= wait_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_id_q    <= rd_id_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rvalid
            assign rvalid_vec[gi] = rd_pend_q && (rd_id_q == 2'(gi));
        end
    endgenerate

    assign gnt0    = gnt_vec[0];
    assign gnt1    = gnt_vec[1];
    assign gnt2    = gnt_vec[2];
    assign rvalid0 = rvalid_vec[0];
    assign rvalid1 = rvalid_vec[1];
    assign rvalid2 = rvalid_vec[2];
    assign rdata   = q_b;

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Directed bench for bram_portb_arbiter with a BRAM model on port B and a read-return scoreboard.
module tb_bram_portb_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req   [3];
    logic          we    [3];
    logic [AW-1:0] addr  [3];
    logic [DW-1:0] wdata [3];
    logic          gnt0, gnt1, gnt2, rvalid0, rvalid1, rvalid2, we_b;
    logic [DW-1:0] rdata, data_b, q_b;
    logic [AW-1:0] addr_b;

    bram_portb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req[0]), .req1(req[1]), .req2(req[2]),
        .we0(we[0]), .we1(we[1]), .we2(we[2]),
        .addr0(addr[0]), .addr1(addr[1]), .addr2(addr[2]),
        .wdata0(wdata[0]), .wdata1(wdata[1]), .wdata2(wdata[2]),
        .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rvalid2(rvalid2),
        .rdata(rdata), .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b)
    );

    always #5 clk = ~clk;

    // Port-B BRAM model, one-cycle registered read.
    logic [DW-1:0] mem    [65536];
    logic [DW-1:0] shadow [65536];
    always @(posedge clk) begin
        if (we_b) mem[addr_b] <= data_b;
        q_b <= mem[addr_b];
    end

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } rd_t;
    rd_t sbq[$];

    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int n, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[n]   = r;
        we[n]    = w;
        addr[n]  = a;
        wdata[n] = d;
    endtask

    // One cycle: check read return, grant and port-B drive, then record what the grant implies.
    task automatic tick(input logic [2:0] exp_gnt, input string tag, input bit assert_rst);
        logic [2:0]    exp_rv;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic          exp_we;
        @(negedge clk);
        exp_rv = 3'b000;
        if (sbq.size() > 0) exp_rv[sbq[0].id] = 1'b1;
        check({tag, "/rvalid"}, 32'({rvalid2, rvalid1, rvalid0}), 32'(exp_rv));
        if (sbq.size() > 0) begin
            check({tag, "/rdata"}, 32'(rdata), 32'(sbq[0].data));
            void'(sbq.pop_front());
        end
        check({tag, "/gnt"}, 32'({gnt2, gnt1, gnt0}), 32'(exp_gnt));
        exp_addr = '0;
        exp_data = '0;
        exp_we   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (exp_gnt[i]) begin
                exp_addr = addr[i];
                exp_data = wdata[i];
                exp_we   = we[i];
                if (we[i]) shadow[addr[i]] = wdata[i];
                else sbq.push_back('{i, shadow[addr[i]]});
            end
        end
        check({tag, "/addr_b"}, 32'(addr_b), 32'(exp_addr));
        check({tag, "/data_b"}, 32'(data_b), 32'(exp_data));
        check({tag, "/we_b"}, 32'(we_b), 32'(exp_we));
        if (assert_rst) begin
            reset_n = 1'b0;
            sbq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]    = 16'(i) ^ 16'h5A5A;
            shadow[i] = 16'(i) ^ 16'h5A5A;
        end
        mem[16'h0040]    = 16'hBEEF;
        shadow[16'h0040] = 16'hBEEF;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, '0, '0);

        // Reset held 3 cycles; requests during reset must not be granted.
        reset_n = 1'b0;
        tick(3'b000, "rst_a", 1'b0);
        drive(0, 1'b1, 1'b1, 16'h0011, 16'hAAAA);
        drive(1, 1'b1, 1'b0, 16'h0022, 16'h0000);
        tick(3'b000, "rst_b", 1'b0);
        tick(3'b000, "rst_c", 1'b0);
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, '0, '0);
        reset_n = 1'b1;
        tick(3'b000, "idle0", 1'b0);
        tick(3'b000, "idle1", 1'b0);

        // Single read by requester 1
        drive(1, 1'b1, 1'b0, 16'h0040, 16'h0000);
        tick(3'b010, "rd1", 1'b0);
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick(3'b000, "rd1_ret", 1'b0);

        // Write then read same address by requester 2
        drive(2, 1'b1, 1'b1, 16'h0100, 16'h1234);
        tick(3'b100, "wr2", 1'b0);
        drive(2, 1'b1, 1'b0, 16'h0100, 16'h0000);
        tick(3'b100, "rd2", 1'b0);
        drive(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick(3'b000, "rd2_ret", 1'b0);

        // Round-robin between 1 and 2
        for (int k = 0; k < 6; k++) begin
            drive(1, 1'b1, 1'b0, 16'(16'h0200 + k), 16'h0000);
            drive(2, 1'b1, 1'b0, 16'(16'h0300 + k), 16'h0000);
            tick((k % 2 == 0) ? 3'b010 : 3'b100, $sformatf("rr%0d", k), 1'b0);
        end
        drive(1, 1'b0, 1'b0, '0, '0);
        drive(2, 1'b0, 1'b0, '0, '0);
        tick(3'b000, "rr_ret", 1'b0);

        // Starvation guard: video and requester 1 both hold requests
        drive(0, 1'b1, 1'b0, 16'h0400, 16'h0000);
        drive(1, 1'b1, 1'b0, 16'h0500, 16'h0000);
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < MW; k++) tick(3'b001, $sformatf("sv%0d_%0d", p, k), 1'b0);
            tick(3'b010, $sformatf("sv%0d_force", p), 1'b0);
        end
        tick(3'b001, "sv_after", 1'b0);
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        tick(3'b000, "sv_ret", 1'b0);

        // Build up wait count and rr_next = 2, then reset right after a video read grant
        drive(0, 1'b1, 1'b0, 16'h0600, 16'h0000);
        drive(2, 1'b1, 1'b0, 16'h0700, 16'h0000);
        for (int k = 0; k < 3; k++) tick(3'b001, $sformatf("pre%0d", k), 1'b0);
        tick(3'b001, "rst_t", 1'b1);
        tick(3'b000, "rst_t1", 1'b0);
        reset_n = 1'b1;

        // All three requesting: fresh wait count gives MW video grants, fresh rr_next picks 1
        drive(1, 1'b1, 1'b0, 16'h0800, 16'h0000);
        for (int k = 0; k < MW; k++) tick(3'b001, $sformatf("post%0d", k), 1'b0);
        tick(3'b010, "post_force", 1'b0);
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, '0, '0);
        tick(3'b000, "drain", 1'b0);
        tick(3'b000, "end", 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
